instr_fetch_buffer: RTL
=======================

Name: instr_fetch_buffer

Overview:
- Consumer end of the program counter's address stream.
- Accepts 8-bit PC values over a valid/ready handshake and issues reads to a synchronous instruction memory with 1-cycle read latency.
- Buffers returned instruction words, each tagged with its PC, in a small FIFO and presents them to the decode stage over a valid/ready handshake.
- Supports a single-cycle flush for branch redirects.

Parameters:
- ADDR_W, 8, width of PC / memory address.
- DATA_W, 16, instruction word width.
- DEPTH, 2, FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- pc_in  in  ADDR_W  PC value to fetch.
- pc_valid  in  1  pc_in is valid.
- pc_ready  out  1  block accepts pc_in this cycle.
- mem_rd  out  1  memory read strobe.
- mem_addr  out  ADDR_W  memory read address.
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_rd.
- instr_out  out  DATA_W  instruction at FIFO head.
- instr_pc  out  ADDR_W  PC tag of instr_out.
- instr_valid  out  1  FIFO head is valid.
- instr_ready  in  1  decode consumes the head this cycle.
- flush  in  1  discard all buffered and in-flight fetches.

Behaviour:
- Reset (async, reset=0):
  - count=0, inflight=0, all FIFO pointers 0.
  - instr_valid=0, instr_out=0, instr_pc=0.
  - pc_ready forced 0 while reset=0, so mem_rd=0.
- pop = instr_valid & instr_ready.
- pc_ready = reset & !flush & ((count + inflight - pop) < DEPTH). Combinational credit check; FIFO can never overflow.
- accept = pc_valid & pc_ready.
- mem_rd = accept; mem_addr = pc_in. Both combinational, same cycle.
- In-flight tracking:
  - On accept, register inflight=1 and inflight_pc=pc_in; otherwise inflight=0 next cycle.
  - One read in flight max per cycle; back-to-back accepts allowed.
- Write: in the cycle after accept (inflight=1 and no flush), write {mem_rdata, inflight_pc} at the write pointer. count increments unless a pop occurs the same cycle.
- Output:
  - instr_valid = (count != 0).
  - instr_out / instr_pc come from the head entry, registered-visible, with no bypass.
- Latency: PC accepted in cycle N produces instr_valid in cycle N+2 (when FIFO was empty).
- Throughput: with instr_ready held 1, one instruction per cycle sustained at DEPTH=2.
- Push and pop in the same cycle: count unchanged, both pointers advance, mod DEPTH wrap.
- Pop with empty FIFO: impossible (instr_valid=0); instr_ready ignored.
- Flush (cycle F):
  - pc_ready=0 in F, so no new accept.
  - count and pointers reset to 0 at the end of F.
  - Any read accepted in F-1 is killed: inflight cleared, its mem_rdata arriving in F is not written.
  - instr_valid=0 from F+1.
  - A pop in F is ignored (no effect beyond the clear).
  - Accepts resume in F+1.
- Flush while empty: no effect beyond holding pc_ready low for one cycle.
- Order: instructions leave in exactly PC acceptance order; no reordering, no duplication.
- Reset mid-operation: immediate clear of all state, including the in-flight read; mem_rdata arriving after reset release with no accept is ignored.
- Widths: count is clog2(DEPTH)+1 bits; pointers are clog2(DEPTH) bits and wrap.

Test Plan:
- Reset: hold reset=0 with pc_valid=1 -> pc_ready=0, mem_rd=0, instr_valid=0, instr_out=0x0000. Release -> pc_ready=1 next cycle.
- Single fetch: pc_in=0x10 accepted at cycle N, memory returns 0xABCD at N+1 -> at N+2 instr_valid=1, instr_out=0xABCD, instr_pc=0x10.
- Streaming: PCs 0x00..0x07 back-to-back with instr_ready=1 -> 8 instructions out on consecutive cycles, in order, pc_ready never drops after the first.
- Backpressure: instr_ready=0, pc_valid=1 continuous -> exactly DEPTH=2 accepts (PCs 0x20, 0x21), then pc_ready=0. Raise instr_ready -> 0x20 then 0x21 emitted, accepts resume.
- Flush with data in flight: FIFO holds 0x30, read for 0x31 in flight, flush=1 -> instr_valid=0 next cycle, 0x31 data never appears. Next accept 0x40 appears at +2 cycles.
- Async reset mid-stream: reset=0 asserted between clock edges with count=2 -> instr_valid drops immediately (no clock edge). After release, no stale data appears.

Source files
------------

// File: rtl/instr_fetch_buffer.sv
// Fetch buffer: takes PCs over a valid/ready handshake, reads a 1-cycle-latency
// instruction memory and queues {instr, pc} pairs for decode. Flush kills all.
module instr_fetch_buffer #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              pc_valid,
  output logic              pc_ready,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] instr_out,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              flush
);

  // Handshakes: a transfer happens on a cycle where valid and ready are both
  // high at the rising edge; valid holds its payload until that transfer.
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

  logic [CNT_W-1:0]  r_count;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic              r_inflight;
  logic [ADDR_W-1:0] r_inflight_pc;
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [ADDR_W-1:0] r_pc   [DEPTH];

  logic              w_pop;
  logic              w_push;
  logic              w_accept;
  logic [CNT_W:0]    w_credit;

  assign instr_valid = (r_count != '0);
  assign w_pop       = instr_valid & instr_ready;

  // Occupancy counts the outstanding read too, so a returning word always has a slot.
  assign w_credit = {1'b0, r_count}
                  + {{CNT_W{1'b0}}, r_inflight}
                  - {{CNT_W{1'b0}}, w_pop};
  assign pc_ready = reset & ~flush & (w_credit < DEPTH_C);
  assign w_accept = pc_valid & pc_ready;
  assign mem_rd   = w_accept;
  assign mem_addr = pc_in;
  assign w_push   = r_inflight & ~flush;

  assign instr_out = r_data[r_rd_ptr];
  assign instr_pc  = r_pc[r_rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else begin
      r_inflight <= w_accept;
      if (w_accept) begin
        r_inflight_pc <= pc_in;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
        r_pc[i]   <= '0;
      end
    end else if (w_push) begin
      r_data[r_wr_ptr] <= mem_rdata;
      r_pc[r_wr_ptr]   <= r_inflight_pc;
    end
  end

endmodule
